circuito_exp5_genius: RTL and testbench
=======================================

# circuito_exp5_genius

Top-level "memory sequence" game for the lab board: the player reproduces a fixed 16-entry sequence on four switches in rounds of growing length (round N requires entries 0..N-1). The block has a control FSM, a datapath (address counter, round-limit counter, play register, sequence ROM, comparator, switch edge detector, timeout counter) and 7-segment debug decoders. It is the complete experiment design and connects directly to board switches, LEDs and HEX displays.

## Interface
- TIMEOUT_CYCLES, default 5000: cycles allowed in the wait-for-play state before a timeout (5 s at 1 kHz).
- clock  in  1  system clock (1 kHz on board).
- reset  in  1  synchronous, active-high; one clock; returns everything to initial state.
- iniciar  in  1  start/restart request, level-sampled.
- chaves  in  4  player switches, one-hot play value.
- pronto  out  1  high in any end state.
- db_igual  out  1  play register equals ROM[address].
- acertou  out  1  high in end-success state.
- errou  out  1  high in end-wrong or end-timeout state.
- leds  out  4  equal to chaves (play echo).
- db_timeout  out  7  7-seg: "1" if timeout occurred, else "0".
- db_contagem  out  7  7-seg of address counter.
- db_memoria  out  7  7-seg of ROM[address].
- db_estado  out  7  7-seg of FSM state code.
- db_jogadafeita  out  7  7-seg of play register.
- db_limite  out  7  7-seg of round-limit counter.
- db_tem_jogada  out  1  one-cycle play-detected pulse.
- db_endmenorquelimite  out  1  address < limit.
- db_clock  out  1  copy of clock.

## Operation
- ROM (combinational read, 16x4): 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex, addresses 0..15).
- Edge detector: registers |chaves; db_tem_jogada=1 for one cycle when |chaves goes 0->1. Holding switches gives one pulse only.
- 7-seg encoding: active-low, bit order gfedcba, hex digits 0..F.
- FSM states (db_estado digit):
  - inicial (0): waits; iniciar=1 -> preparacao.
  - preparacao (1): clear address, limit, play register, timeout flag/counter -> inicio_rodada.
  - inicio_rodada (2): clear address and timeout counter -> espera_jogada.
  - espera_jogada (3): timeout counter increments; tem_jogada -> registra; counter reaching TIMEOUT_CYCLES-1 -> fim_timeout.
  - registra (4): play register <= chaves -> comparacao.
  - comparacao (5): mismatch -> fim_errou; match and address<limit -> proxima_jogada; match and address==limit: limit==15 -> fim_acertou, else -> proxima_rodada.
  - proxima_jogada (6): address+1, clear timeout counter -> espera_jogada.
  - proxima_rodada (7): limit+1 -> inicio_rodada.
  - fim_acertou (A), fim_errou (E), fim_timeout (D): hold; iniciar=1 -> preparacao.
- pronto=1 in A/E/D; acertou=1 only in A; errou=1 in E and D; all combinational from state.
- Address and limit are 4-bit; limit never exceeds 15 (checked before increment), so no wrap.

## Timing
- After reset: state inicial, pronto/acertou/errou=0, address=limit=play register=0, timeout flag 0, db_tem_jogada=0.
- iniciar seen in inicial -> espera_jogada 2 cycles later.
- chaves 0->nonzero: tem_jogada next edge; registra, comparacao, then proxima_jogada/proxima_rodada; back in espera_jogada within 5 cycles of the switch change. Switches released >=1 cycle before next press.
- Timeout counter counts only in espera_jogada; cleared on every new play/round; timeout flag set on entry to fim_timeout.
- iniciar held in inicial or end state restarts once; iniciar ignored in other states.
- Reset mid-game -> inicial next edge regardless of state.

## Test plan
- Reset 10 cycles -> db_estado="0", pronto=0, db_contagem="0", db_limite="0".
- iniciar pulse, round 1 play 0001 -> comparacao match, address==limit=0 -> proxima_rodada, db_limite="1".
- Full 16 rounds with ROM sequence (each press 5 cycles, release 5) -> fim_acertou, pronto=1, acertou=1, errou=0, db_estado="A".
- From fim_acertou, iniciar 5 cycles -> preparacao, limit 0, acertou=0; repeat 16 rounds -> acertou again.
- Round 2, second play 0100 instead of 0010 -> fim_errou, errou=1, db_estado="E", db_igual=0.
- After iniciar, no press for TIMEOUT_CYCLES -> fim_timeout, errou=1, pronto=1, db_timeout="1", db_estado="D".

Source files
------------

// File: rtl/circuito_exp5_genius.sv
// rtl/circuito_exp5_genius.sv - memory-sequence game: control FSM, datapath, sequence ROM and 7-seg debug decoders
module circuito_exp5_genius #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       db_igual,
    output logic       acertou,
    output logic       errou,
    output logic [3:0] leds,
    output logic [6:0] db_timeout,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_limite,
    output logic       db_tem_jogada,
    output logic       db_endmenorquelimite,
    output logic       db_clock
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

    estado_t estado, estado_prox;

    logic [3:0]    endereco;
    logic [3:0]    limite;
    logic [3:0]    jogada;
    logic [3:0]    memoria;
    logic [CW-1:0] conta_timeout;
    logic          flag_timeout;
    logic          chaves_ativas_q;
    logic          tem_jogada;
    logic          igual;
    logic          end_menor;

    logic zera_end, conta_end, zera_lim, conta_lim, zera_jog, registra_jog;
    logic zera_to, conta_to, zera_flag, seta_flag;

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'h40;
            4'h1: hex7seg = 7'h79;
            4'h2: hex7seg = 7'h24;
            4'h3: hex7seg = 7'h30;
            4'h4: hex7seg = 7'h19;
            4'h5: hex7seg = 7'h12;
            4'h6: hex7seg = 7'h02;
            4'h7: hex7seg = 7'h78;
            4'h8: hex7seg = 7'h00;
            4'h9: hex7seg = 7'h10;
            4'hA: hex7seg = 7'h08;
            4'hB: hex7seg = 7'h03;
            4'hC: hex7seg = 7'h46;
            4'hD: hex7seg = 7'h21;
            4'hE: hex7seg = 7'h06;
            default: hex7seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        memoria = 4'h1;
        case (endereco)
            4'h0: memoria = 4'h1;
            4'h1: memoria = 4'h2;
            4'h2: memoria = 4'h4;
            4'h3: memoria = 4'h8;
            4'h4: memoria = 4'h4;
            4'h5: memoria = 4'h2;
            4'h6: memoria = 4'h1;
            4'h7: memoria = 4'h1;
            4'h8: memoria = 4'h2;
            4'h9: memoria = 4'h2;
            4'hA: memoria = 4'h4;
            4'hB: memoria = 4'h4;
            4'hC: memoria = 4'h8;
            4'hD: memoria = 4'h8;
            4'hE: memoria = 4'h1;
            default: memoria = 4'h4;
        endcase
    end

    // A play is the rising edge of "any switch on"; holding gives one pulse.
    assign tem_jogada = (|chaves) & ~chaves_ativas_q;
    assign igual      = (jogada == memoria);
    assign end_menor  = (endereco < limite);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= INICIAL;
            endereco        <= 4'd0;
            limite          <= 4'd0;
            jogada          <= 4'd0;
            conta_timeout   <= '0;
            flag_timeout    <= 1'b0;
            chaves_ativas_q <= 1'b0;
        end else begin
            estado          <= estado_prox;
            chaves_ativas_q <= |chaves;

            if (zera_end)       endereco <= 4'd0;
            else if (conta_end) endereco <= endereco + 4'd1;

            if (zera_lim)       limite <= 4'd0;
            else if (conta_lim) limite <= limite + 4'd1;

            if (zera_jog)          jogada <= 4'd0;
            else if (registra_jog) jogada <= chaves;

            if (zera_to)       conta_timeout <= '0;
            else if (conta_to) conta_timeout <= conta_timeout + CW'(1);

            if (zera_flag)      flag_timeout <= 1'b0;
            else if (seta_flag) flag_timeout <= 1'b1;
        end
    end

    always_comb begin
        estado_prox  = estado;
        zera_end     = 1'b0;
        conta_end    = 1'b0;
        zera_lim     = 1'b0;
        conta_lim    = 1'b0;
        zera_jog     = 1'b0;
        registra_jog = 1'b0;
        zera_to      = 1'b0;
        conta_to     = 1'b0;
        zera_flag    = 1'b0;
        seta_flag    = 1'b0;
        case (estado)
            INICIAL: begin
                if (iniciar) estado_prox = PREPARACAO;
            end
            PREPARACAO: begin
                zera_end    = 1'b1;
                zera_lim    = 1'b1;
                zera_jog    = 1'b1;
                zera_to     = 1'b1;
                zera_flag   = 1'b1;
                estado_prox = INICIO_RODADA;
            end
            INICIO_RODADA: begin
                zera_end    = 1'b1;
                zera_to     = 1'b1;
                estado_prox = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                conta_to = 1'b1;
                if (tem_jogada) begin
                    estado_prox = REGISTRA;
                end else if (conta_timeout == TO_LAST) begin
                    seta_flag   = 1'b1;
                    estado_prox = FIM_TIMEOUT;
                end
            end
            REGISTRA: begin
                registra_jog = 1'b1;
                estado_prox  = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual)              estado_prox = FIM_ERROU;
                else if (end_menor)      estado_prox = PROXIMA_JOGADA;
                else if (limite == 4'hF) estado_prox = FIM_ACERTOU;
                else                     estado_prox = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA: begin
                conta_end   = 1'b1;
                zera_to     = 1'b1;
                estado_prox = ESPERA_JOGADA;
            end
            PROXIMA_RODADA: begin
                conta_lim   = 1'b1;
                estado_prox = INICIO_RODADA;
            end
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
                if (iniciar) estado_prox = PREPARACAO;
            end
            default: estado_prox = INICIAL;
        endcase
    end

    assign pronto  = (estado == FIM_ACERTOU) || (estado == FIM_ERROU) || (estado == FIM_TIMEOUT);
    assign acertou = (estado == FIM_ACERTOU);
    assign errou   = (estado == FIM_ERROU) || (estado == FIM_TIMEOUT);

    assign leds                 = chaves;
    assign db_igual             = igual;
    assign db_tem_jogada        = tem_jogada;
    assign db_endmenorquelimite = end_menor;
    assign db_clock             = clock;
    assign db_timeout           = hex7seg({3'b000, flag_timeout});
    assign db_contagem          = hex7seg(endereco);
    assign db_memoria           = hex7seg(memoria);
    assign db_estado            = hex7seg(estado);
    assign db_jogadafeita       = hex7seg(jogada);
    assign db_limite            = hex7seg(limite);

endmodule

// File: tb/tb_circuito_exp5_genius.sv
// tb/tb_circuito_exp5_genius.sv - directed bench for the memory-sequence game
module tb_circuito_exp5_genius;

    localparam int TO = 40;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [3:0] SEQ [16] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
    };

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'h0;
    logic       pronto, db_igual, acertou, errou;
    logic [3:0] leds;
    logic [6:0] db_timeout, db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite;
    logic       db_tem_jogada, db_endmenorquelimite, db_clock;

    int tests = 0;
    int fails = 0;

    circuito_exp5_genius #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .pronto(pronto), .db_igual(db_igual), .acertou(acertou), .errou(errou),
        .leds(leds), .db_timeout(db_timeout), .db_contagem(db_contagem),
        .db_memoria(db_memoria), .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
        .db_limite(db_limite), .db_tem_jogada(db_tem_jogada),
        .db_endmenorquelimite(db_endmenorquelimite), .db_clock(db_clock)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        iniciar = 1'b0;
        chaves  = 4'h0;
        reset   = 1'b1;
        tick(2);
        reset   = 1'b0;
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tick(2);
    endtask

    task automatic play(input logic [3:0] v);
        chaves = v;
        tick(5);
        chaves = 4'h0;
        tick(5);
    endtask

    task automatic play_all_rounds();
        for (int r = 0; r < 16; r++)
            for (int i = 0; i <= r; i++)
                play(SEQ[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(10);
        reset = 1'b0;
        #1;
        tests++; if (db_estado !== SEG[0]) begin fails++; $display("FAIL reset_estado got %b want %b", db_estado, SEG[0]); end
        tests++; if (pronto !== 1'b0) begin fails++; $display("FAIL reset_pronto got %b want 0", pronto); end
        tests++; if (db_contagem !== SEG[0]) begin fails++; $display("FAIL reset_contagem got %b want %b", db_contagem, SEG[0]); end
        tests++; if (db_limite !== SEG[0]) begin fails++; $display("FAIL reset_limite got %b want %b", db_limite, SEG[0]); end
        tests++; if (db_timeout !== SEG[0]) begin fails++; $display("FAIL reset_timeout got %b want %b", db_timeout, SEG[0]); end
        tests++; if ({acertou, errou, db_tem_jogada} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {acertou, errou, db_tem_jogada}); end
    endtask

    task automatic test_round1();
        do_reset();
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tests++; if (db_estado !== SEG[1]) begin fails++; $display("FAIL r1_prep got %b want %b", db_estado, SEG[1]); end
        tick(2);
        tests++; if (db_estado !== SEG[3]) begin fails++; $display("FAIL r1_espera got %b want %b", db_estado, SEG[3]); end
        chaves = 4'b0001;
        #1;
        tests++; if (db_tem_jogada !== 1'b1) begin fails++; $display("FAIL r1_pulse got %b want 1", db_tem_jogada); end
        tests++; if (leds !== 4'b0001) begin fails++; $display("FAIL r1_leds got %b want 0001", leds); end
        tick(1);
        tests++; if (db_estado !== SEG[4] || db_tem_jogada !== 1'b0) begin fails++; $display("FAIL r1_registra got %b/%b want %b/0", db_estado, db_tem_jogada, SEG[4]); end
        tick(1);
        tests++; if (db_estado !== SEG[5] || db_igual !== 1'b1) begin fails++; $display("FAIL r1_compara got %b/%b want %b/1", db_estado, db_igual, SEG[5]); end
        tick(1);
        tests++; if (db_estado !== SEG[7]) begin fails++; $display("FAIL r1_prox_rodada got %b want %b", db_estado, SEG[7]); end
        tick(1);
        tests++; if (db_estado !== SEG[2] || db_limite !== SEG[1]) begin fails++; $display("FAIL r1_limite got %b/%b want %b/%b", db_estado, db_limite, SEG[2], SEG[1]); end
        tick(1);
        tests++; if (db_estado !== SEG[3] || db_endmenorquelimite !== 1'b1) begin fails++; $display("FAIL r2_espera got %b/%b want %b/1", db_estado, db_endmenorquelimite, SEG[3]); end
        chaves = 4'h0;
        tick(2);
    endtask

    task automatic test_full_game();
        do_reset();
        start_game();
        play_all_rounds();
        tests++; if (db_estado !== SEG[10]) begin fails++; $display("FAIL full_estado got %b want %b", db_estado, SEG[10]); end
        tests++; if ({pronto, acertou, errou} !== 3'b110) begin fails++; $display("FAIL full_outs got %b want 110", {pronto, acertou, errou}); end
        tests++; if (db_limite !== SEG[15]) begin fails++; $display("FAIL full_limite got %b want %b", db_limite, SEG[15]); end
    endtask

    task automatic test_restart();
        iniciar = 1'b1;
        tick(1);
        tests++; if (db_estado !== SEG[1] || acertou !== 1'b0 || pronto !== 1'b0) begin fails++; $display("FAIL rs_prep got %b/%b/%b want %b/0/0", db_estado, acertou, pronto, SEG[1]); end
        tick(1);
        tests++; if (db_limite !== SEG[0]) begin fails++; $display("FAIL rs_limite got %b want %b", db_limite, SEG[0]); end
        tick(3);
        iniciar = 1'b0;
        tests++; if (db_estado !== SEG[3]) begin fails++; $display("FAIL rs_espera got %b want %b", db_estado, SEG[3]); end
        play_all_rounds();
        tests++; if (db_estado !== SEG[10] || acertou !== 1'b1) begin fails++; $display("FAIL rs_acertou got %b/%b want %b/1", db_estado, acertou, SEG[10]); end
    endtask

    task automatic test_wrong_play();
        do_reset();
        start_game();
        play(4'b0001);
        play(4'b0001);
        play(4'b0100);
        tests++; if (db_estado !== SEG[14]) begin fails++; $display("FAIL wr_estado got %b want %b", db_estado, SEG[14]); end
        tests++; if ({pronto, acertou, errou, db_igual} !== 4'b1010) begin fails++; $display("FAIL wr_outs got %b want 1010", {pronto, acertou, errou, db_igual}); end
        tests++; if (db_jogadafeita !== SEG[4] || db_contagem !== SEG[1]) begin fails++; $display("FAIL wr_regs got %b/%b want %b/%b", db_jogadafeita, db_contagem, SEG[4], SEG[1]); end
    endtask

    task automatic test_timeout();
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        tests++; if (db_estado !== SEG[1]) begin fails++; $display("FAIL to_prep got %b want %b", db_estado, SEG[1]); end
        tick(1);
        tests++; if (db_timeout !== SEG[0]) begin fails++; $display("FAIL to_flag_clear got %b want %b", db_timeout, SEG[0]); end
        tick(TO);
        tests++; if (db_estado !== SEG[3]) begin fails++; $display("FAIL to_still_espera got %b want %b", db_estado, SEG[3]); end
        tick(1);
        tests++; if (db_estado !== SEG[13]) begin fails++; $display("FAIL to_estado got %b want %b", db_estado, SEG[13]); end
        tests++; if ({pronto, acertou, errou} !== 3'b101) begin fails++; $display("FAIL to_outs got %b want 101", {pronto, acertou, errou}); end
        tests++; if (db_timeout !== SEG[1]) begin fails++; $display("FAIL to_flag got %b want %b", db_timeout, SEG[1]); end
    endtask

    task automatic test_reset_midgame();
        do_reset();
        start_game();
        play(4'b0001);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tests++; if (db_estado !== SEG[0] || db_limite !== SEG[0]) begin fails++; $display("FAIL mid_reset got %b/%b want %b/%b", db_estado, db_limite, SEG[0], SEG[0]); end
        tests++; if (db_clock !== clock) begin fails++; $display("FAIL db_clock got %b want %b", db_clock, clock); end
    endtask

    initial begin
        test_reset();
        test_round1();
        test_full_game();
        test_restart();
        test_wrong_play();
        test_timeout();
        test_reset_midgame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
